// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// Runs mult/multu (fixed MUL_LAT-cycle latency) and div/divu (DATA_W
// radix-2 restoring steps on operand magnitudes, then one sign-fix cycle).
// HI/LO can also be written directly by mthi/mtlo while the unit is idle.
//
// Ports
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   start         request a new operation (taken only when idle)
//   alu_md        00 mult, 01 multu, 10 div, 11 divu (sampled with start)
//   a, b          rs / rt operands, latched when start is accepted
//   mthi, mtlo    write wdata into HI / LO (taken only when idle)
//   wdata         data for mthi/mtlo
//   mf_req        mfhi/mflo in EX; only contributes to stall
//   flush         abandon any in-flight operation, no HI/LO update
//   hi, lo        committed HI / LO registers
//   busy          operation in flight
//   done          one-cycle pulse when HI/LO were just written by mult/div
//   stall         busy and the pipeline wants the unit or its registers
module md_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        alu_md,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mf_req,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   a_reg, a_next;      // original operands, kept for sign fix
  logic [DATA_W-1:0]   b_reg, b_next;
  logic                sgn_reg, sgn_next;  // signed operation
  logic [DATA_W-1:0]   rem_reg, rem_next;  // partial remainder (magnitude)
  logic [DATA_W-1:0]   quo_reg, quo_next;  // dividend shifts out, quotient shifts in
  logic [DATA_W-1:0]   hi_reg, hi_next;
  logic [DATA_W-1:0]   lo_reg, lo_next;
  logic                done_reg, done_next;

  // Operand sign / magnitude helpers
  logic                a_neg, b_neg, in_sgn;
  logic [DATA_W-1:0]   dvs_mag, in_a_mag;
  logic [DATA_W:0]     shifted, diff;
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;

  assign a_neg    = sgn_reg & a_reg[DATA_W-1];
  assign b_neg    = sgn_reg & b_reg[DATA_W-1];
  assign dvs_mag  = b_neg ? -b_reg : b_reg;
  assign in_sgn   = ~alu_md[0];
  assign in_a_mag = (in_sgn & a[DATA_W-1]) ? -a : a;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted  = {rem_reg, quo_reg[DATA_W-1]};
  assign diff     = shifted - {1'b0, dvs_mag};

  // Extending both operands to 2*DATA_W lets one unsigned multiplier serve
  // both forms: the low 2*DATA_W bits of the product are the same either way.
  assign mul_a_ext = {{DATA_W{a_neg}}, a_reg};
  assign mul_b_ext = {{DATA_W{b_neg}}, b_reg};
  assign product   = mul_a_ext * mul_b_ext;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next   = a;
          b_next   = b;
          sgn_next = in_sgn;
          cnt_next = '0;
          if (alu_md[1]) begin
            state_next = DIV;
            rem_next   = '0;
            quo_next   = in_a_mag;
          end else begin
            state_next = MUL;
          end
        end else begin
          if (mthi) hi_next = wdata;
          if (mtlo) lo_next = wdata;
        end
      end
      MUL: begin
        if (cnt_reg == MUL_LAST) begin
          hi_next    = product[2*DATA_W-1:DATA_W];
          lo_next    = product[DATA_W-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DIV: begin
        if (diff[DATA_W]) begin
          rem_next = shifted[DATA_W-1:0];
          quo_next = {quo_reg[DATA_W-2:0], 1'b0};
        end else begin
          rem_next = diff[DATA_W-1:0];
          quo_next = {quo_reg[DATA_W-2:0], 1'b1};
        end
        if (cnt_reg == DIV_LAST) state_next = FIX;
        else                     cnt_next   = cnt_reg + CNT_W'(1);
      end
      FIX: begin
        // Zero divisor gives a fixed result regardless of signedness.
        if (b_reg == '0) begin
          lo_next = '1;
          hi_next = a_reg;
        end else begin
          lo_next = (a_neg ^ b_neg) ? -quo_reg : quo_reg;
          hi_next = a_neg ? -rem_reg : rem_reg;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Flush cancels whatever the unit would do this edge, including an
    // idle-time start or mthi/mtlo from the cancelled instruction.
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = done_reg;
  assign stall = busy & (start | mthi | mtlo | mf_req);

  // mthi/mtlo in the same idle cycle as start would be silently dropped.
  a_start_with_mt: assert property (@(posedge clk) disable iff (rst)
    !(state_reg == IDLE && start && (mthi || mtlo)));

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  localparam int W  = 32;
  localparam int ML = 2;
  localparam int DL = W + 1;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo, mf_req, flush;
  logic [1:0]   alu_md;
  logic [W-1:0] a, b, wdata;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  always #5 clk = ~clk;

  md_unit #(.DATA_W(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_md(alu_md), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint   sp;
    logic [63:0] up;
    int       sx, sy;
    logic [W-1:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      2'd0: begin sp = longint'(sx) * longint'(sy); return 64'(sp); end
      2'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Present an operation for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; alu_md = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; alu_md = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_lat,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    check({name, " done_seen"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    check({name, " busy_after"}, 64'(busy), 64'd0);
    $display("op %s: hi=%h lo=%h latency=%0d", name, hi, lo, lat);
  endtask

  initial begin
    logic [63:0]  m;
    logic [W-1:0] h0, l0, mh, ml;
    logic [1:0]   op;
    logic [W-1:0] ra, rb;
    bit           seen;

    vecs[0] = '{2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{2'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{2'd3, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'd1, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};

    rst = 1'b1; start = 0; alu_md = 0; a = 0; b = 0;
    mthi = 0; mtlo = 0; wdata = 0; mf_req = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    rst = 1'b0;
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].op[1] ? DL : ML, vecs[i].exp_hi, vecs[i].exp_lo);
      @(posedge clk); #1;
      check($sformatf("vec%0d done_pulse_width", i), 64'(done), 64'd0);
    end

    // mtlo while a div is running: stalled and ignored, then re-issued
    l0 = lo;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    mtlo = 1'b1; wdata = 32'h1234;
    #1;
    check("mtlo_busy stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    check("mtlo_busy lo_kept", 64'(lo), 64'(l0));
    wait_done("div_with_mtlo", DL - 4, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_after lo", 64'(lo), 64'h1234);
    check("mtlo_after hi", 64'(hi), 64'hFFFF_FFFF);
    $display("mtlo after done: lo=%h", lo);

    // Flush ten cycles into a div
    h0 = hi; l0 = lo; seen = 0;
    issue(2'd3, 32'd1000, 32'd3);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("flush no_done", 64'(seen), 64'd0);
    check("flush hi_kept", 64'(hi), 64'(h0));
    check("flush lo_kept", 64'(lo), 64'(l0));
    $display("flush: hi=%h lo=%h busy=%b", hi, lo, busy);

    // Back-to-back: second start in the done cycle
    issue(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("b2b_first", ML, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(2'd3, 32'd100, 32'd7);
    check("b2b second_accepted busy", 64'(busy), 64'd1);
    wait_done("b2b_second", DL - 1 + 1, 32'd2, 32'd14);

    // Randomized operations and idle register writes against the model
    mh = hi; ml = lo;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      m = model(op, ra, rb);
      issue(op, ra, rb);
      mf_req = 1'b1;
      #1;
      check($sformatf("rnd%0d stall_mf", i), 64'(stall), 64'd1);
      mf_req = 1'b0;
      wait_done($sformatf("rnd%0d op%0d", i, op), op[1] ? DL : ML, m[63:32], m[31:0]);
      mh = m[63:32]; ml = m[31:0];
      mthi = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
      if (mthi) mh = wdata;
      if (mtlo) ml = wdata;
      @(posedge clk); #1;
      mthi = 0; mtlo = 0;
      check($sformatf("rnd%0d mt hi", i), 64'(hi), 64'(mh));
      check($sformatf("rnd%0d mt lo", i), 64'(lo), 64'(ml));
    end

    // Reset in the middle of a mult
    issue(2'd1, 32'hFFFF_FFFF, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid hi", 64'(hi), 64'd0);
    check("rst_mid lo", 64'(lo), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("rst_mid no_done", 64'(seen), 64'd0);
    $display("reset mid-mult: hi=%h lo=%h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
